// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main sequencing FSM for the multi-cycle RV32I core
module multicycle_control (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        branch_cond,
    output logic [2:0]  ImmSrc,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic        pc_src,
    output logic        mem_req,
    output logic        mem_we,
    output logic        adr_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  result_src,
    output logic        retire,
    output logic        illegal,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12,
        S_AUIPC    = 4'd13,
        S_TRAP     = 4'd14
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [6:0] w_opcode;
    logic       w_is_store;
    logic       w_is_shift;
    logic       w_unused_instr;

    assign w_opcode       = instr[6:0];
    assign w_is_store     = instr[5];
    assign w_is_shift     = (instr[13:12] == 2'b01);
    assign w_unused_instr = ^{instr[31:14], instr[11:7]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (w_opcode)
                    7'b0000011, 7'b0100011: w_next = S_MEMADR;
                    7'b0110011:             w_next = S_EXECR;
                    7'b0010011:             w_next = S_EXECI;
                    7'b1100011:             w_next = S_BRANCH;
                    7'b1101111:             w_next = S_JAL;
                    7'b1100111:             w_next = S_JALR;
                    7'b0110111:             w_next = S_LUI;
                    7'b0010111:             w_next = S_AUIPC;
                    default:                w_next = S_TRAP;
                endcase
            end
            S_MEMADR:   w_next = w_is_store ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: w_next = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    w_next = S_ALUWB;
            S_EXECI:    w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BRANCH:   w_next = S_FETCH;
            S_JAL:      w_next = S_FETCH;
            S_JALR:     w_next = S_FETCH;
            S_LUI:      w_next = S_FETCH;
            S_AUIPC:    w_next = S_FETCH;
            S_TRAP:     w_next = S_TRAP;
            default:    w_next = S_FETCH;
        endcase
    end

    // Held reset gates every strobe so an in-flight memory request drops immediately.
    always_comb begin
        ImmSrc     = 3'b000;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        pc_src     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        result_src = 2'b00;
        retire     = 1'b0;
        if (rst_n) begin
            case (r_state)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = 2'b10;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    ImmSrc    = 3'b010;
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                end
                S_MEMADR: begin
                    ImmSrc    = w_is_store ? 3'b001 : 3'b000;
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    result_src = 2'b01;
                    retire     = 1'b1;
                end
                S_MEMWRITE: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    adr_src = 1'b1;
                    retire  = mem_ready;
                end
                S_EXECR: begin
                    alu_src_a = 2'b10;
                    alu_op    = 2'b10;
                end
                S_EXECI: begin
                    ImmSrc    = w_is_shift ? 3'b101 : 3'b000;
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    alu_op    = 2'b10;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 2'b10;
                    alu_op    = 2'b01;
                    pc_write  = branch_cond;
                    pc_src    = 1'b1;
                    retire    = 1'b1;
                end
                S_JAL: begin
                    ImmSrc     = 3'b100;
                    alu_src_a  = 2'b01;
                    alu_src_b  = 2'b01;
                    pc_write   = 1'b1;
                    reg_write  = 1'b1;
                    result_src = 2'b11;
                    retire     = 1'b1;
                end
                S_JALR: begin
                    alu_src_a  = 2'b10;
                    alu_src_b  = 2'b01;
                    pc_write   = 1'b1;
                    reg_write  = 1'b1;
                    result_src = 2'b11;
                    retire     = 1'b1;
                end
                S_LUI: begin
                    ImmSrc     = 3'b011;
                    alu_src_b  = 2'b01;
                    alu_op     = 2'b11;
                    reg_write  = 1'b1;
                    result_src = 2'b10;
                    retire     = 1'b1;
                end
                S_AUIPC: begin
                    ImmSrc     = 3'b011;
                    alu_src_a  = 2'b01;
                    alu_src_b  = 2'b01;
                    reg_write  = 1'b1;
                    result_src = 2'b10;
                    retire     = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign illegal = (r_state == S_TRAP);
    assign state   = r_state;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multi-cycle RV32I core. It sequences one shared ALU, one unified memory port, the register file and the immediate generator through fetch, decode, execute, memory and writeback. Every cycle it drives the 3-bit immediate-format select consumed by the sign-extension unit. It sits between the instruction register / ALU flag outputs and all datapath write-enables and mux selects.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- instr  in  32  instruction register contents; stable from DECODE until the next FETCH completes
- mem_ready  in  1  memory handshake; the request is accepted in the cycle mem_req=1 and mem_ready=1
- branch_cond  in  1  ALU comparison result for funct3 of the current branch (1 = taken)
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 U, 100 J, 101 5-bit zero-extended shamt
- ir_write, pc_write, reg_write  out  1 each  register write strobes
- pc_src  out  1  0 = ALU result, 1 = ALUOut register
- mem_req, mem_we  out  1 each  memory request / write qualifier
- adr_src  out  1  0 = PC, 1 = ALUOut
- alu_src_a  out  2  00 PC, 01 oldPC, 10 rs1
- alu_src_b  out  2  00 rs2, 01 immediate, 10 constant 4
- alu_op  out  2  00 add, 01 branch compare, 10 funct3/funct7 decode, 11 pass B
- result_src  out  2  00 ALUOut, 01 memory read data, 10 ALU result, 11 PC
- retire  out  1  one-cycle pulse in the final cycle of each instruction
- illegal  out  1  sticky; high in TRAP
- state  out  4  current state encoding (debug)

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, JALR 11, LUI 12, AUIPC 13, TRAP 14. Encoding 15 is unreachable. If state 15 is ever reached, the next state is FETCH.
- Outputs are decoded combinationally from the registered state and the inputs. Any output not listed for a state is 0.
- FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00.
  - If mem_ready=1: ir_write=1, pc_write=1, pc_src=0, go to DECODE.
  - Else: stay in FETCH.
- DECODE: ImmSrc=010, alu_src_a=01, alu_src_b=01, alu_op=00. This precomputes the branch target into ALUOut.
  - Next state from instr[6:0]: 0000011 or 0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1100011 → BRANCH; 1101111 → JAL; 1100111 → JALR; 0110111 → LUI; 0010111 → AUIPC.
  - Any other opcode → TRAP.
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00.
  - ImmSrc=000 for loads, 001 for stores.
  - Loads → MEMREAD; stores → MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1. Go to MEMWB on mem_ready, else stay.
- MEMWB: reg_write=1, result_src=01, retire=1, go to FETCH.
- MEMWRITE: mem_req=1, mem_we=1, adr_src=1. On mem_ready: retire=1, go to FETCH; else stay.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10, go to ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10, go to ALUWB.
  - ImmSrc=101 when funct3 is 001 or 101 (shifts); otherwise ImmSrc=000.
- ALUWB: reg_write=1, result_src=00, retire=1, go to FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, retire=1, go to FETCH.
  - pc_write=branch_cond, pc_src=1.
- JAL: ImmSrc=100, alu_src_a=01, alu_src_b=01, alu_op=00, pc_write=1, pc_src=0, reg_write=1, result_src=11, retire=1, go to FETCH.
- JALR: ImmSrc=000, alu_src_a=10, alu_src_b=01, alu_op=00, pc_write=1, pc_src=0, reg_write=1, result_src=11, retire=1, go to FETCH.
- LUI: ImmSrc=011, alu_src_b=01, alu_op=11, reg_write=1, result_src=10, retire=1, go to FETCH.
- AUIPC: ImmSrc=011, alu_src_a=01, alu_src_b=01, alu_op=00, reg_write=1, result_src=10, retire=1, go to FETCH.
- TRAP: illegal=1. All strobes are 0. Only reset leaves TRAP.
- Writes to rd=x0 are not suppressed here; the register file ignores them.

## Timing
- Reset:
  - rst_n=0 sampled at a rising edge → state=FETCH.
  - While rst_n=0, all strobes are forced to 0 and ImmSrc=000.
  - Reset mid-transaction abandons the access; mem_req drops in the same cycle.
- Cycles with zero memory wait states:
  - branch 3; JAL, JALR, LUI, AUIPC 3
  - R-type, I-ALU 4; store 4
  - load 5
- Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- mem_req is held high, with constant address select, until mem_ready=1. mem_ready is ignored when mem_req=0.
- JAL/JALR: reg_write and pc_write are asserted in the same cycle. rd receives the pre-update PC, i.e. the link address.
- retire is high for exactly 1 cycle per instruction. It is never high in FETCH, DECODE or TRAP.

## Test plan
- Reset then addi x1,x0,5 (0x00500093), mem_ready=1 → states 0,1,7,8,0; ImmSrc=000 in EXECI; reg_write and retire in cycle 4.
- slli x2,x1,3 (0x00309113) → ImmSrc=101 in EXECI.
- Load lw x3,8(x0), mem_ready low 2 cycles in MEMREAD:
  - ImmSrc=000 in MEMADR.
  - mem_req held 3 cycles, adr_src=1.
  - MEMWB follows; total 7 cycles.
- Store sw x3,4(x0) → ImmSrc=001 in MEMADR; mem_we=1 in MEMWRITE.
- beq with branch_cond=0 → pc_write=0; with branch_cond=1 → pc_write=1, pc_src=1. ImmSrc=010 in DECODE; 3 cycles each.
- jal x1,16 → ImmSrc=100, pc_write=1, reg_write=1, result_src=11 in JAL.
- Opcode 0x7F → TRAP, illegal=1 sticky for 10 cycles.
- rst_n=0 mid-MEMREAD → mem_req=0 that cycle; state=FETCH next.
